// File: rtl/runway_scheduler_pkg.sv
// Shared types and constants for the runway clearance scheduler.
package runway_scheduler_pkg;
  typedef enum logic [1:0] {IDLE, OFFER, SETTLE} state_e;

  localparam logic GRANT_TAKEOFF = 1'b0;
  localparam logic GRANT_LANDING = 1'b1;
  localparam int   NUM_RUNWAYS   = 2;
endpackage

// File: rtl/runway_scheduler_if.sv
// Queue status, runway locks and grant handshake between the traffic side and the scheduler.
interface runway_scheduler_if;
  import runway_scheduler_pkg::*;

  logic                   takeoff_pending;
  logic                   landing_pending;
  logic                   emergency;
  logic [NUM_RUNWAYS-1:0] runway_active;
  logic                   grant_ready;
  logic                   grant_valid;
  logic                   grant_landing;
  logic                   grant_runway;
  logic [NUM_RUNWAYS-1:0] runway_timeout;
  logic [1:0]             land_streak;

  modport master (
    output takeoff_pending, landing_pending, emergency, runway_active, grant_ready,
    input  grant_valid, grant_landing, grant_runway, runway_timeout, land_streak
  );

  modport slave (
    input  takeoff_pending, landing_pending, emergency, runway_active, grant_ready,
    output grant_valid, grant_landing, grant_runway, runway_timeout, land_streak
  );
endinterface

// File: rtl/runway_scheduler_occupancy_timer.sv
// Per-runway occupancy counter; one-cycle pulse when a lock has been held OCC_TIMEOUT cycles.
module occupancy_timer #(
  parameter int OCC_TIMEOUT = 1000,
  parameter int CNT_W       = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic active_i,
  output logic timeout_o
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(OCC_TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // Saturating at LIMIT keeps the pulse from repeating until the lock drops.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    if (!active_i) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d     = cnt_q + 1'b1;
      timeout_d = (cnt_q == LIMIT - 1'b1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
endmodule

// File: rtl/runway_scheduler.sv
// Picks the next plane and runway: landings first, bounded by a takeoff-starvation streak.
module runway_scheduler
  import runway_scheduler_pkg::*;
#(
  parameter int MAX_LAND_STREAK = 3,
  parameter int OCC_TIMEOUT     = 1000,
  parameter int CNT_W           = 10
) (
  input  logic              clock,
  input  logic              reset,
  runway_scheduler_if.slave bus
);
  localparam logic [1:0] STREAK_MAX = 2'(MAX_LAND_STREAK);

  state_e     state_q;
  logic       valid_q;
  logic       land_q;
  logic       rwy_q;
  logic [1:0] streak_q;

  logic [NUM_RUNWAYS-1:0] timeout;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      land_q   <= GRANT_TAKEOFF;
      rwy_q    <= 1'b0;
      streak_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!bus.emergency && !(&bus.runway_active) &&
              (bus.takeoff_pending || bus.landing_pending)) begin
            state_q <= OFFER;
            valid_q <= 1'b1;
            rwy_q   <= bus.runway_active[0];
            land_q  <= (bus.landing_pending &&
                        !(bus.takeoff_pending && streak_q == STREAK_MAX))
                       ? GRANT_LANDING : GRANT_TAKEOFF;
          end
        end
        OFFER: begin
          // Accept beats emergency when both arrive together.
          if (bus.grant_ready) begin
            state_q <= SETTLE;
            valid_q <= 1'b0;
            if (land_q == GRANT_LANDING && bus.takeoff_pending)
              streak_q <= (streak_q == STREAK_MAX) ? streak_q : streak_q + 2'd1;
            else
              streak_q <= '0;
          end else if (bus.emergency) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        SETTLE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_RUNWAYS; i++) begin : g_occ
    occupancy_timer #(
      .OCC_TIMEOUT(OCC_TIMEOUT),
      .CNT_W      (CNT_W)
    ) u_timer (
      .clock    (clock),
      .reset    (reset),
      .active_i (bus.runway_active[i]),
      .timeout_o(timeout[i])
    );
  end

  assign bus.grant_valid    = valid_q;
  assign bus.grant_landing  = land_q;
  assign bus.grant_runway   = rwy_q;
  assign bus.land_streak    = streak_q;
  assign bus.runway_timeout = timeout;
endmodule

// File: doc/runway_scheduler.md
Name: runway_scheduler

Overview:
- Decides which queued plane gets cleared next, and onto which runway.
- Sits between the takeoff/landing FIFO status flags and the request FSM's clear path, and replaces the fixed alternate-every-cycle choice.
- Landings have priority, bounded by a takeoff-starvation counter. Emergency blocks all clearances.
- Also watches each runway's occupancy time and raises a timeout pulse for a stuck runway.

Parameters:
- MAX_LAND_STREAK, 3: consecutive landing grants allowed while a takeoff waits; the next grant is forced to takeoff.
- OCC_TIMEOUT, 1000: cycles a runway may stay active before runway_timeout fires.
- CNT_W, 10: occupancy counter width; must satisfy 2^CNT_W > OCC_TIMEOUT.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- takeoff_pending  in  1  takeoff FIFO non-empty
- landing_pending  in  1  landing FIFO non-empty
- emergency  in  1  emergency flag; blocks all grants
- runway_active  in  2  bit i set means runway i is locked
- grant_ready  in  1  consumer accepts the grant (unqueue + lock)
- grant_valid  out  1  a grant is offered
- grant_landing  out  1  1 = landing grant, 0 = takeoff grant
- grant_runway  out  1  runway index granted
- runway_timeout  out  2  one-cycle pulse per runway on occupancy timeout
- land_streak  out  2  current landing-streak count (debug)

Behaviour:
- Reset: state IDLE; grant_valid=0, grant_landing=0, grant_runway=0, runway_timeout=0, land_streak=0, occupancy counters=0. All outputs are registered.
- States: IDLE, OFFER, SETTLE.
- IDLE:
  - Move to OFFER when emergency=0, runway_active!=2'b11, and (takeoff_pending or landing_pending).
  - Otherwise stay in IDLE.
  - On entering OFFER, register the grant fields:
    - grant_runway = 0 if runway_active[0]=0, else 1.
    - grant_landing = 1 if landing_pending and not (takeoff_pending and land_streak==MAX_LAND_STREAK).
    - Otherwise grant_landing = 0.
- OFFER:
  - grant_valid=1. The payload stays stable until accepted.
  - When grant_ready=1 in a cycle: handshake completes, next state SETTLE, grant_valid drops next cycle.
  - Landing grant with takeoff_pending=1: land_streak increments, saturating at MAX_LAND_STREAK.
  - Takeoff grant, or landing grant with takeoff_pending=0: land_streak clears to 0.
  - Abort if emergency=1 while grant_ready=0: withdraw the offer (grant_valid=0 next cycle), return to IDLE, land_streak unchanged.
  - The grant is not re-evaluated while offered. Pending or runway changes take effect only at the next IDLE decision.
- SETTLE:
  - One cycle unconditionally, then IDLE.
  - Lets runway_active reflect the new lock, so the same runway is never granted twice.
- Occupancy timer, per runway i, independent of the FSM:
  - If runway_active[i]=0, counter clears to 0.
  - Otherwise it increments, saturating at OCC_TIMEOUT.
  - runway_timeout[i] pulses for exactly one cycle on the cycle the counter reaches OCC_TIMEOUT.
  - No repeat pulse until the runway is released and re-locked.
- Simultaneous events:
  - Accept and emergency in the same cycle: the accept wins.
  - Both runways free: runway 0 is granted.
  - Nothing pending: stay in IDLE with no output change.
- Reset mid-operation: any pending offer is dropped at once with no handshake; the streak and timers are cleared.

Decomposition:
- Shared package holds:
  - state enum {IDLE, OFFER, SETTLE}
  - localparams GRANT_TAKEOFF=1'b0, GRANT_LANDING=1'b1
  - runway count constant NUM_RUNWAYS=2
- One natural sub-module, occupancy_timer (parameters OCC_TIMEOUT, CNT_W; inputs active; output timeout pulse). Instantiate it twice.

Test Plan:
1. Streak limit: after reset, landing_pending=1, takeoff_pending=1, runway_active=00, grant_ready=1 each offer. Required grant_landing sequence: 1,1,1,0,1,1,1,0. land_streak goes 1,2,3 then back to 0.
2. Runway choice: runway_active=01, takeoff_pending=1 only → grant_runway=1, grant_landing=0. With runway_active=11, grant_valid must stay 0 for 20 cycles.
3. Handshake hold: grant_ready held low for 5 cycles → grant_valid=1 with a stable payload throughout. After grant_ready=1, grant_valid goes low the next cycle, followed by one SETTLE cycle, and no new offer earlier than 2 cycles later.
4. Emergency: assert emergency during OFFER with grant_ready=0 → grant_valid=0 next cycle and land_streak unchanged. With emergency held, no grant occurs even when both queues are pending.
5. Timeout, OCC_TIMEOUT=8: set runway_active[1]=1 for 20 cycles → a single runway_timeout[1] pulse 8 cycles after activation. Drop and re-raise runway_active[1] → the pulse repeats after 8 cycles. runway_timeout[0] stays 0 throughout.
6. Reset during OFFER → next cycle grant_valid=0, land_streak=0, state IDLE. Both counters cleared: a runway still active must not time out until OCC_TIMEOUT cycles after reset.
